// File: rtl/shift_deser.sv
// rtl/shift_deser.sv - serial-to-parallel receiver with one holding stage and sticky overrun
module shift_deser #(
  parameter int WIDTH = 10
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       serial_in,
  input  logic                       shift_en,
  input  logic                       frame_sync,
  input  logic                       out_ready,
  input  logic                       ovr_clr,
  output logic [WIDTH-1:0]           data_out,
  output logic                       data_valid,
  output logic                       overrun,
  output logic [$clog2(WIDTH+1)-1:0] bit_cnt
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    COLLECT = 1'b0,
    FULL    = 1'b1
  } state_t;

  state_t             r_state;
  // Only the upper WIDTH-1 bits of the shift register are ever reused.
  logic [WIDTH-2:0]   r_sr;
  logic [WIDTH-1:0]   r_data;
  logic [CW-1:0]      r_cnt;
  logic               r_ovr;

  logic [CW-1:0]      w_cnt_base;
  logic [WIDTH-1:0]   w_word;
  logic               w_complete;
  logic               w_free;
  logic               w_consume;

  assign w_cnt_base = frame_sync ? '0 : r_cnt;
  assign w_word     = {serial_in, r_sr};
  assign w_complete = shift_en && (w_cnt_base == LAST);
  assign w_free     = (r_state == COLLECT) || out_ready;
  assign w_consume  = (r_state == FULL) && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= COLLECT;
      r_sr    <= '0;
      r_data  <= '0;
      r_cnt   <= '0;
      r_ovr   <= 1'b0;
    end else begin
      if (shift_en) begin
        r_sr <= w_word[WIDTH-1:1];
      end

      if (w_complete) begin
        r_cnt <= '0;
      end else if (shift_en) begin
        r_cnt <= w_cnt_base + CW'(1);
      end else begin
        r_cnt <= w_cnt_base;
      end

      if (w_complete && w_free) begin
        r_data <= w_word;
      end

      // A fresh drop beats a coincident clear.
      if (w_complete && !w_free) begin
        r_ovr <= 1'b1;
      end else if (ovr_clr) begin
        r_ovr <= 1'b0;
      end

      case (r_state)
        COLLECT: if (w_complete) r_state <= FULL;
        FULL:    if (w_consume && !w_complete) r_state <= COLLECT;
        default: r_state <= COLLECT;
      endcase
    end
  end

  assign data_out   = r_data;
  assign data_valid = (r_state == FULL);
  assign overrun    = r_ovr;
  assign bit_cnt    = r_cnt;

endmodule

// File: tb/tb_shift_deser.sv
// tb/tb_shift_deser.sv - scoreboard bench for shift_deser against a bit-list reference model
module tb_shift_deser;

  localparam int W  = 10;
  localparam int CW = $clog2(W + 1);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;
  logic          serial_in = 1'b0;
  logic          shift_en = 1'b0;
  logic          frame_sync = 1'b0;
  logic          out_ready = 1'b0;
  logic          ovr_clr = 1'b0;
  logic [W-1:0]  data_out;
  logic          data_valid;
  logic          overrun;
  logic [CW-1:0] bit_cnt;

  shift_deser #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .serial_in  (serial_in),
    .shift_en   (shift_en),
    .frame_sync (frame_sync),
    .out_ready  (out_ready),
    .ovr_clr    (ovr_clr),
    .data_out   (data_out),
    .data_valid (data_valid),
    .overrun    (overrun),
    .bit_cnt    (bit_cnt)
  );

  int n_vec  = 0;
  int n_fail = 0;

  // Reference model: received bits kept as a list, word value built by arithmetic.
  bit           rx_bits[$];
  logic [W-1:0] sb[$];
  logic         m_valid = 1'b0;
  logic         m_ovr   = 1'b0;
  logic [W-1:0] m_data  = '0;
  bit           mon_en  = 1'b0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void model_step(logic se, logic si, logic fs, logic rdy, logic clr, logic rs);
    logic consume;
    logic accepted;
    logic dropped;
    int   word;
    if (rs) begin
      rx_bits.delete();
      sb.delete();
      m_valid = 1'b0;
      m_ovr   = 1'b0;
      m_data  = '0;
      return;
    end
    consume  = m_valid && rdy;
    accepted = 1'b0;
    dropped  = 1'b0;
    word     = 0;
    if (fs) rx_bits.delete();
    if (se) begin
      rx_bits.push_back(si);
      if (rx_bits.size() == W) begin
        for (int i = 0; i < W; i++) word += rx_bits[i] ? (1 << i) : 0;
        rx_bits.delete();
        if (!m_valid || rdy) accepted = 1'b1;
        else dropped = 1'b1;
      end
    end
    if (accepted) begin
      m_data  = W'(word);
      m_valid = 1'b1;
      sb.push_back(W'(word));
    end else if (consume) begin
      m_valid = 1'b0;
    end
    if (dropped) m_ovr = 1'b1;
    else if (clr) m_ovr = 1'b0;
  endfunction

  task automatic cyc(input logic se, input logic si, input logic fs,
                     input logic rdy, input logic clr, input logic rs);
    shift_en   = se;
    serial_in  = si;
    frame_sync = fs;
    out_ready  = rdy;
    ovr_clr    = clr;
    rst        = rs;
    @(posedge clk);
    #1;
    model_step(se, si, fs, rdy, clr, rs);
  endtask

  // rdy_mode: 0 never ready, 1 always ready, 2 ready only on the completing bit
  task automatic send_word(input logic [W-1:0] w, input int rdy_mode, input int maxgap);
    logic [W-1:0] v;
    int gaps;
    v = w;
    for (int i = 0; i < W; i++) begin
      gaps = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
      for (int g = 0; g < gaps; g++)
        cyc(1'b0, 1'($urandom), 1'b0, rdy_mode == 1, 1'b0, 1'b0);
      cyc(1'b1, v[i], 1'b0, (rdy_mode == 1) || (rdy_mode == 2 && i == W - 1), 1'b0, 1'b0);
    end
  endtask

  initial begin
    logic [W-1:0] exp_w;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        chk("data_valid", 32'(data_valid), 32'(m_valid));
        chk("overrun", 32'(overrun), 32'(m_ovr));
        chk("bit_cnt", 32'(bit_cnt), 32'(rx_bits.size()));
        chk("data_out_held", 32'(data_out), 32'(m_data));
        if (data_valid && out_ready && !rst) begin
          if (sb.size() == 0) begin
            n_vec++;
            n_fail++;
            $display("FAIL scoreboard: word %0h presented with nothing expected", data_out);
          end else begin
            exp_w = sb.pop_front();
            chk("scoreboard_word", 32'(data_out), 32'(exp_w));
          end
        end
      end
    end
  end

  initial begin
    logic [W-1:0] d;
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    mon_en = 1'b1;
    chk("reset_data", 32'(data_out), 32'h0);
    chk("reset_valid", 32'(data_valid), 32'h0);
    chk("reset_ovr", 32'(overrun), 32'h0);
    chk("reset_cnt", 32'(bit_cnt), 32'h0);

    send_word(10'h2B5, 0, 0);
    chk("tp1_data", 32'(data_out), 32'h2B5);
    chk("tp1_valid", 32'(data_valid), 32'h1);
    chk("tp1_cnt", 32'(bit_cnt), 32'h0);
    chk("tp1_ovr", 32'(overrun), 32'h0);

    send_word(10'h155, 0, 0);
    chk("tp2_data", 32'(data_out), 32'h2B5);
    chk("tp2_ovr", 32'(overrun), 32'h1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("tp2_ovr_clr", 32'(overrun), 32'h0);

    send_word(10'h3FF, 2, 0);
    chk("tp3_data", 32'(data_out), 32'h3FF);
    chk("tp3_valid", 32'(data_valid), 32'h1);
    chk("tp3_ovr", 32'(overrun), 32'h0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("tp3_consumed", 32'(data_valid), 32'h0);

    for (int i = 0; i < 4; i++) cyc(1'b1, 1'($urandom), 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("tp4_sync_cnt", 32'(bit_cnt), 32'h1);
    for (int i = 0; i < 9; i++) cyc(1'b1, 1'($urandom), 1'b0, 1'b0, 1'b0, 1'b0);
    d = data_out;
    chk("tp4_valid", 32'(data_valid), 32'h1);
    chk("tp4_bit0", 32'(d[0]), 32'h1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    for (int k = 0; k < 4; k++) send_word(W'($urandom), 1, 3);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    send_word(W'($urandom), 0, 0);
    send_word(W'($urandom), 0, 0);
    for (int i = 0; i < 6; i++) cyc(1'b1, 1'($urandom), 1'b0, 1'b0, 1'b0, 1'b0);
    chk("tp6_pre_valid", 32'(data_valid), 32'h1);
    chk("tp6_pre_ovr", 32'(overrun), 32'h1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("tp6_rst_data", 32'(data_out), 32'h0);
    chk("tp6_rst_valid", 32'(data_valid), 32'h0);
    chk("tp6_rst_ovr", 32'(overrun), 32'h0);
    chk("tp6_rst_cnt", 32'(bit_cnt), 32'h0);
    send_word(10'h2A7, 0, 0);
    chk("tp6_word", 32'(data_out), 32'h2A7);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    for (int n = 0; n < 600; n++)
      cyc(($urandom % 4) != 0, 1'($urandom), ($urandom % 40) == 0,
          ($urandom % 3) != 0, ($urandom % 25) == 0, ($urandom % 200) == 0);
    for (int n = 0; n < 3; n++) cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
